// File: rtl/sys_array_pkg.sv
// Shared types, sizing helpers and the hex segment table for the result display.
// Used by sys_array_result_display and hex_to_7seg.
package sys_array_pkg;

    typedef enum logic [0:0] {
        CAPTURE = 1'b0,
        DISPLAY = 1'b1
    } state_t;

    function automatic int calc_n(input int w, input int l);
        return w * l;
    endfunction

    function automatic int calc_p(input int n);
        return (n + 3) / 4;
    endfunction

    function automatic int width_of(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Active-low segments {g,f,e,d,c,b,a}, indexed by nibble value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
    import sys_array_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sys_array_result_display.sv
// Captures the systolic array result stream and pages it four elements at a time.
// Optional segment decoder output enabled by SYS_ARRAY_DISP_SEG_EN.
module sys_array_result_display
    import sys_array_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int ARRAY_W      = 4,
    parameter  int ARRAY_L      = 4,
    parameter  int DWELL_CYCLES = 25000000,
    localparam int N            = calc_n(ARRAY_W, ARRAY_L),
    localparam int P            = calc_p(N),
    localparam int PG_W         = width_of(P),
    localparam int CNT_W        = cnt_width(N)
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    disp_valid,
    output logic [4*DATA_WIDTH-1:0] disp_data,
    output logic [PG_W-1:0]         page_idx,
`ifdef SYS_ARRAY_DISP_SEG_EN
    output logic [7*DATA_WIDTH-1:0] seg_out,
`endif
    output logic [CNT_W-1:0]        count
);

    localparam int PTR_W  = width_of(N);
    localparam int DW_W   = width_of(DWELL_CYCLES);
    localparam int DISP_W = 4 * DATA_WIDTH;

    state_t                  state_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [DW_W-1:0]         dwell_r;
    logic [DATA_WIDTH-1:0]   buf_r [N];
    logic                    accept_s;
    logic                    done_s;
    logic                    dwell_tc_s;
    logic [PG_W-1:0]         last_page_s;
    logic [DISP_W-1:0]       page_s;

    assign accept_s    = in_valid && in_ready && !clear;
    assign done_s      = accept_s && (in_last || (wr_ptr_r == PTR_W'(N - 1)));
    assign dwell_tc_s  = (dwell_r == DW_W'(DWELL_CYCLES - 1));
    // Paging stops at the last page holding a captured element, so an early
    // in_last does not cycle through empty pages. count is >= 1 in DISPLAY.
    assign last_page_s = PG_W'((count - CNT_W'(1)) >> 2);

    // Page assembly: slots beyond the captured count read as zero
    always_comb begin
        page_s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < N; j++) begin
                page_s[k*DATA_WIDTH +: DATA_WIDTH] = page_s[k*DATA_WIDTH +: DATA_WIDTH] |
                    (((int'(page_idx) * 4 + k) == j) && (j < int'(count)) ? buf_r[j] : '0);
            end
        end
    end

    // Result buffer write port
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_r[wr_ptr_r] <= in_data;
        end
    end

    // Control FSM with registered handshake and display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= CAPTURE;
            wr_ptr_r   <= '0;
            count      <= '0;
            page_idx   <= '0;
            dwell_r    <= '0;
            in_ready   <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else if (clear) begin
            state_r    <= CAPTURE;
            wr_ptr_r   <= '0;
            count      <= '0;
            page_idx   <= '0;
            dwell_r    <= '0;
            in_ready   <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            case (state_r)
                CAPTURE: begin
                    in_ready   <= !done_s;
                    disp_valid <= 1'b0;
                    disp_data  <= '0;
                    if (accept_s) begin
                        count <= count + CNT_W'(1);
                        if (done_s) begin
                            state_r  <= DISPLAY;
                            page_idx <= '0;
                            dwell_r  <= '0;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        end
                    end
                end
                DISPLAY: begin
                    in_ready   <= 1'b0;
                    disp_valid <= 1'b1;
                    disp_data  <= page_s;
                    if (dwell_tc_s) begin
                        dwell_r  <= '0;
                        page_idx <= (page_idx == last_page_s) ? '0 : page_idx + PG_W'(1);
                    end else begin
                        dwell_r <= dwell_r + DW_W'(1);
                    end
                end
                default: begin
                    state_r    <= CAPTURE;
                    in_ready   <= 1'b1;
                    disp_valid <= 1'b0;
                    disp_data  <= '0;
                end
            endcase
        end
    end

`ifdef SYS_ARRAY_DISP_SEG_EN
    logic [7*DATA_WIDTH-1:0] seg_s;

    for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_digit
        hex_to_7seg u_dec (
            .nibble (page_s[d*4 +: 4]),
            .seg    (seg_s[d*7 +: 7])
        );
    end

    // Segment register, blank whenever disp_valid will be low
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seg_out <= '1;
        end else if (state_r == DISPLAY) begin
            seg_out <= seg_s;
        end else begin
            seg_out <= '1;
        end
    end
`endif

endmodule
